alu_hs_iter: RTL

// - Parametrised ALU with valid/ready handshakes on its operand and result sides; sits between the register-file/control FSM and the UART TX path.
// - Single-cycle ops produce a registered result one cycle after accept; DIV/MOD run on an iterative restoring divider.
// - Output is held under back-pressure. Status flags accompany every result.

---
 rtl/alu_hs_iter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/alu_hs_iter.sv
// alu_hs_iter: handshaked ALU; single-cycle ops register in one cycle, DIV/MOD use a restoring divider
// that produces one quotient bit per cycle. The result register is held under back-pressure.
module alu_hs_iter #(
  parameter int OPER_WIDTH = 8,
  parameter bit SHIFT_BY_B = 1'b0
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [OPER_WIDTH-1:0]   A,
  input  logic [OPER_WIDTH-1:0]   B,
  input  logic [3:0]              ALU_FUN,
  input  logic                    IN_VALID,
  output logic                    IN_READY,
  output logic [2*OPER_WIDTH-1:0] ALU_OUT,
  output logic [2:0]              FLAGS,
  output logic                    OUT_VALID,
  input  logic                    OUT_READY,
  output logic                    BUSY
);
  localparam int W  = OPER_WIDTH;
  localparam int OW = 2 * W;
  localparam int SW = $clog2(W);

  typedef enum logic {S_IDLE, S_DIV} state_t;

  state_t        r_state, w_state_nxt;
  logic [OW-1:0] r_out, w_res, w_dres, w_az, w_bz, w_sum, w_diff;
  logic [2:0]    r_flags, w_flags;
  logic          r_out_valid, r_is_mod;
  logic [W-1:0]  r_quo, r_rem, r_dvs, w_quo_nxt, w_rem_nxt;
  logic [W:0]    w_shift, w_sub;
  logic [SW-1:0] r_cnt, w_sh;
  logic          w_carry, w_dz, w_out_free, w_accept, w_is_divmod;
  logic          w_div_start, w_last, w_single_load, w_div_load;

  assign w_out_free    = !r_out_valid || OUT_READY;
  assign IN_READY      = (r_state == S_IDLE) && w_out_free;
  assign w_accept      = IN_VALID && IN_READY;
  assign w_is_divmod   = (ALU_FUN == 4'h3) || (ALU_FUN == 4'hF);
  assign w_div_start   = w_accept && w_is_divmod && (B != '0);
  assign w_single_load = w_accept && !(w_is_divmod && (B != '0));
  assign w_last        = r_cnt == SW'(W - 1);
  // the final iteration only commits once the output register can take the result
  assign w_div_load    = (r_state == S_DIV) && w_last && w_out_free;

  assign ALU_OUT   = r_out;
  assign FLAGS     = r_flags;
  assign OUT_VALID = r_out_valid;
  assign BUSY      = r_state == S_DIV;

  assign w_az   = {{W{1'b0}}, A};
  assign w_bz   = {{W{1'b0}}, B};
  assign w_sum  = w_az + w_bz;
  assign w_diff = w_az - w_bz;
  assign w_sh   = SHIFT_BY_B ? B[SW-1:0] : SW'(1);

  assign w_shift   = {r_rem, r_quo[W-1]};
  assign w_sub     = w_shift - {1'b0, r_dvs};
  assign w_rem_nxt = w_sub[W] ? w_shift[W-1:0] : w_sub[W-1:0];
  assign w_quo_nxt = {r_quo[W-2:0], ~w_sub[W]};
  assign w_dres    = r_is_mod ? {{W{1'b0}}, w_rem_nxt} : {{W{1'b0}}, w_quo_nxt};

  always_ff @(posedge CLK or negedge RST)
    if (!RST) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_state_nxt = (r_state == S_IDLE) ? (w_div_start ? S_DIV : S_IDLE)
                                      : (w_div_load ? S_IDLE : S_DIV);
  end

  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    w_dz    = 1'b0;
    case (ALU_FUN)
      4'h0: begin
        w_res   = w_sum;
        w_carry = w_sum[W];
      end
      4'h1: begin
        w_res   = w_diff;
        w_carry = A < B;
      end
      4'h2: w_res = w_az * w_bz;
      4'h3: begin
        w_res = {{W{1'b0}}, {W{1'b1}}};
        w_dz  = B == '0;
      end
      4'h4: w_res = {{W{1'b0}}, A & B};
      4'h5: w_res = {{W{1'b0}}, A | B};
      4'h6: w_res = {{W{1'b0}}, ~(A & B)};
      4'h7: w_res = {{W{1'b0}}, ~(A | B)};
      4'h8: w_res = {{W{1'b0}}, A ^ B};
      4'h9: w_res = {{W{1'b0}}, ~(A ^ B)};
      4'hA: w_res = (A == B) ? OW'(1) : '0;
      4'hB: w_res = (A > B) ? OW'(2) : '0;
      4'hC: w_res = (A < B) ? OW'(3) : '0;
      4'hD: w_res = {{W{1'b0}}, A >> w_sh};
      4'hE: w_res = w_az << w_sh;
      default: begin
        w_res = w_az;
        w_dz  = B == '0;
      end
    endcase
    w_flags = {w_dz, w_carry, w_res == '0};
  end

  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      r_quo    <= '0;
      r_rem    <= '0;
      r_dvs    <= '0;
      r_cnt    <= '0;
      r_is_mod <= 1'b0;
    end else if (w_div_start) begin
      r_quo    <= A;
      r_rem    <= '0;
      r_dvs    <= B;
      r_cnt    <= '0;
      r_is_mod <= ALU_FUN == 4'hF;
    end else if (r_state == S_DIV && !w_last) begin
      r_quo <= w_quo_nxt;
      r_rem <= w_rem_nxt;
      r_cnt <= r_cnt + SW'(1);
    end

  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      r_out       <= '0;
      r_flags     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_single_load) begin
        r_out   <= w_res;
        r_flags <= w_flags;
      end else if (w_div_load) begin
        r_out   <= w_dres;
        r_flags <= {2'b00, w_dres == '0};
      end
      r_out_valid <= (w_single_load || w_div_load) ? 1'b1 : (OUT_READY ? 1'b0 : r_out_valid);
    end
endmodule
